// File: rtl/ifetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_stage_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
   localparam logic [XLEN-1:0] PC_INC       = 32'd4;

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_DISCARD = 2'd1,
      S_HOLD    = 2'd2
   } fetch_state_t;

   // Force a byte address onto a word boundary.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~(XLEN'(3));
   endfunction

endpackage

// File: rtl/ifetch_stage_reg32.sv
// 32-bit capture register with synchronous clear, used for the IR and its PC.
module ifetch_stage_reg32
   import ifetch_stage_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            we,
   input  logic [XLEN-1:0] d,
   output logic [XLEN-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (we) begin
         q <= d;
      end
   end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: request/ack memory fetch, redirect handling and
// a one-deep instruction hold register feeding decode.
module ifetch_stage
   import ifetch_stage_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
)(
   input  logic            CLK,
   input  logic            Reset,
   input  logic [XLEN-1:0] PC_New,
   input  logic            PC_LdNew,
   input  logic            Stall,
   output logic [XLEN-1:0] Mem_Addr,
   output logic            Mem_Req,
   input  logic            Mem_Ack,
   input  logic [XLEN-1:0] Mem_Rdata,
   output logic [XLEN-1:0] Instr,
   output logic [XLEN-1:0] PC_Out,
   output logic            Instr_Valid
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] redir_q, redir_d;
   logic            valid_q;
   logic            capture;
   logic [XLEN-1:0] new_target;

   assign new_target = word_align(PC_New);

   // State, PC and redirect registers.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= S_FETCH;
         pc_q    <= word_align(RESET_PC);
         redir_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         redir_q <= redir_d;
         valid_q <= (state_d == S_HOLD);
      end
   end

   // Next-state logic; redirect beats ack, ack beats stall.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      redir_d = redir_q;
      capture = 1'b0;

      case (state_q)
         S_FETCH: begin
            if (PC_LdNew) begin
               if (Mem_Ack) begin
                  pc_d = new_target;
               end else begin
                  redir_d = new_target;
                  state_d = S_DISCARD;
               end
            end else if (Mem_Ack) begin
               capture = 1'b1;
               pc_d    = pc_q + PC_INC;
               state_d = S_HOLD;
            end
         end

         // Outstanding fetch must drain before the redirect takes effect.
         S_DISCARD: begin
            if (PC_LdNew) begin
               redir_d = new_target;
            end
            if (Mem_Ack) begin
               pc_d    = PC_LdNew ? new_target : redir_q;
               state_d = S_FETCH;
            end
         end

         S_HOLD: begin
            if (PC_LdNew) begin
               pc_d    = new_target;
               state_d = S_FETCH;
            end else if (!Stall) begin
               state_d = S_FETCH;
            end
         end

         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // Request is suppressed while Reset is high so a stale fetch never escapes.
   assign Mem_Req     = !Reset && (state_q != S_HOLD);
   assign Mem_Addr    = pc_q;
   assign Instr_Valid = valid_q;

   ifetch_stage_reg32 u_ir (
      .clk   (CLK),
      .reset (Reset),
      .we    (capture),
      .d     (Mem_Rdata),
      .q     (Instr)
   );

   ifetch_stage_reg32 u_ir_pc (
      .clk   (CLK),
      .reset (Reset),
      .we    (capture),
      .d     (pc_q),
      .q     (PC_Out)
   );

endmodule

// File: tb/tb_ifetch_stage.sv
// Bench for ifetch_stage: directed scenarios then random traffic, checked
// against a transaction-level model of two instances with different reset PCs.
module tb_ifetch_stage;

   logic        CLK = 1'b0;
   logic        Reset = 1'b1;
   logic [31:0] PC_New = '0;
   logic        PC_LdNew = 1'b0;
   logic        Stall = 1'b0;
   logic        Mem_Ack = 1'b0;
   logic [31:0] Mem_Rdata = '0;

   logic [31:0] addr0, instr0, pco0, addr1, instr1, pco1;
   logic        req0, valid0, req1, valid1;

   int errors = 0;
   int checks = 0;

   // Model: per instance, fetch address, held instruction and drop-in-flight flag.
   logic [31:0] m_rpc   [2] = '{32'h0000_0000, 32'hFFFF_FFFC};
   logic [31:0] m_pc    [2];
   logic [31:0] m_tgt   [2];
   logic [31:0] m_instr [2];
   logic [31:0] m_pco   [2];
   bit          m_have  [2];
   bit          m_drop  [2];

   always #5 CLK = ~CLK;

   ifetch_stage #(.RESET_PC(32'h0000_0000)) dut0 (
      .CLK(CLK), .Reset(Reset), .PC_New(PC_New), .PC_LdNew(PC_LdNew), .Stall(Stall),
      .Mem_Addr(addr0), .Mem_Req(req0), .Mem_Ack(Mem_Ack), .Mem_Rdata(Mem_Rdata),
      .Instr(instr0), .PC_Out(pco0), .Instr_Valid(valid0)
   );

   ifetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
      .CLK(CLK), .Reset(Reset), .PC_New(PC_New), .PC_LdNew(PC_LdNew), .Stall(Stall),
      .Mem_Addr(addr1), .Mem_Req(req1), .Mem_Ack(Mem_Ack), .Mem_Rdata(Mem_Rdata),
      .Instr(instr1), .PC_Out(pco1), .Instr_Valid(valid1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_update(input int k, input bit rst, input bit ld, input logic [31:0] nw,
                               input bit ack, input logic [31:0] rd, input bit st);
      logic [31:0] tgt;
      tgt = nw & 32'hFFFF_FFFC;
      if (rst) begin
         m_pc[k] = m_rpc[k]; m_tgt[k] = '0; m_instr[k] = '0; m_pco[k] = '0;
         m_have[k] = 0; m_drop[k] = 0;
      end else if (m_have[k]) begin
         if (ld) begin
            m_pc[k] = tgt; m_have[k] = 0;
         end else if (!st) begin
            m_have[k] = 0;
         end
      end else if (m_drop[k]) begin
         if (ld) m_tgt[k] = tgt;
         if (ack) begin
            m_pc[k] = m_tgt[k]; m_drop[k] = 0;
         end
      end else begin
         if (ld && ack) begin
            m_pc[k] = tgt;
         end else if (ld) begin
            m_tgt[k] = tgt; m_drop[k] = 1;
         end else if (ack) begin
            m_instr[k] = rd; m_pco[k] = m_pc[k]; m_pc[k] = m_pc[k] + 32'd4; m_have[k] = 1;
         end
      end
   endtask

   task automatic check_all();
      chk("req0",   32'(req0),   32'(!Reset && !m_have[0]));
      chk("addr0",  addr0,       m_pc[0]);
      chk("valid0", 32'(valid0), 32'(m_have[0]));
      chk("instr0", instr0,      m_instr[0]);
      chk("pco0",   pco0,        m_pco[0]);
      chk("req1",   32'(req1),   32'(!Reset && !m_have[1]));
      chk("addr1",  addr1,       m_pc[1]);
      chk("valid1", 32'(valid1), 32'(m_have[1]));
      chk("instr1", instr1,      m_instr[1]);
      chk("pco1",   pco1,        m_pco[1]);
   endtask

   // One clock: drive inputs, check at the falling edge, then advance the model.
   task automatic step(input bit rst, input bit ld, input logic [31:0] nw,
                       input bit ack, input logic [31:0] rd, input bit st);
      Reset = rst; PC_LdNew = ld; PC_New = nw; Mem_Ack = ack; Mem_Rdata = rd; Stall = st;
      @(negedge CLK);
      check_all();
      @(posedge CLK);
      #1;
      for (int k = 0; k < 2; k++) model_update(k, rst, ld, nw, ack, rd, st);
   endtask

   initial begin
      Reset = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      for (int k = 0; k < 2; k++) model_update(k, 1, 0, '0, 0, '0, 0);
      step(1, 0, '0, 0, '0, 0);

      // First fetch acknowledged immediately after reset.
      step(0, 0, '0, 1, 32'h2000_0005, 0);
      chk("d_valid",  32'(valid0), 32'd1);
      chk("d_instr",  instr0,      32'h2000_0005);
      chk("d_pcout",  pco0,        32'h0000_0000);
      chk("d_req",    32'(req0),   32'd0);
      chk("d_wpcout", pco1,        32'hFFFF_FFFC);
      chk("d_waddr",  addr1,       32'h0000_0000);

      repeat (3) step(0, 0, '0, 1, 32'hBAD0_BAD0, 1);
      chk("d_stall_instr", instr0,      32'h2000_0005);
      chk("d_stall_valid", 32'(valid0), 32'd1);
      step(0, 0, '0, 0, '0, 0);
      chk("d_next_addr", addr0, 32'h0000_0004);

      // Redirect while waiting; ack two cycles later is dropped.
      step(0, 1, 32'h0000_0103, 0, '0, 0);
      step(0, 0, '0, 0, '0, 0);
      step(0, 0, '0, 1, 32'h1111_1111, 0);
      chk("d_redir_addr",  addr0,       32'h0000_0100);
      chk("d_redir_valid", 32'(valid0), 32'd0);

      // Redirect coincident with ack.
      step(0, 1, 32'h0000_0040, 1, 32'h2222_2222, 0);
      chk("d_coinc_addr",  addr0,       32'h0000_0040);
      chk("d_coinc_valid", 32'(valid0), 32'd0);

      // Reset while a request is outstanding and acked.
      step(0, 0, '0, 1, 32'h0000_1234, 0);
      step(0, 0, '0, 0, '0, 0);
      step(1, 0, '0, 1, 32'hDEAD_BEEF, 0);
      chk("d_rst_instr", instr0,      32'h0000_0000);
      chk("d_rst_valid", 32'(valid0), 32'd0);
      chk("d_rst_addr",  addr0,       32'h0000_0000);
      chk("d_rst_waddr", addr1,       32'hFFFF_FFFC);
      step(0, 0, '0, 0, '0, 0);

      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, $urandom,
              $urandom_range(0, 9) < 4, $urandom, $urandom_range(0, 1) == 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ifetch_stage.md
IFETCH_STAGE -- requirements
Module: ifetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] SHALL be 00.
REQ-002 CLK  input  1  sole clock; all state SHALL update on rising edge only.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-004 PC_New  input  32  redirect target from branch/jump logic.
REQ-005 PC_LdNew  input  1  redirect strobe; single-cycle pulse, may repeat.
REQ-006 Stall  input  1  downstream not ready; holds the current instruction.
REQ-007 Mem_Addr  output  32  instruction memory word address (byte-addressed, word-aligned).
REQ-008 Mem_Req  output  1  fetch request; held high until Mem_Ack.
REQ-009 Mem_Ack  input  1  memory response valid; Mem_Rdata valid in the same cycle.
REQ-010 Mem_Rdata  input  32  fetched instruction word.
REQ-011 Instr  output  32  registered instruction to decode (feeds the IR reg32 stage).
REQ-012 PC_Out  output  32  registered address of Instr.
REQ-013 Instr_Valid  output  1  Instr/PC_Out valid this cycle.

Function
REQ-014 FSM states SHALL be: S_FETCH, S_DISCARD, S_HOLD.
REQ-015 S_FETCH: Mem_Req=1, Mem_Addr=PC; on Mem_Ack with no PC_LdNew: Instr<=Mem_Rdata, PC_Out<=PC, PC<=PC+4, go S_HOLD.
REQ-016 S_FETCH, no Mem_Ack: remain; Mem_Addr SHALL stay stable while Mem_Req is high.
REQ-017 S_FETCH, PC_LdNew and Mem_Ack together: discard Mem_Rdata, PC<={PC_New[31:2],2'b00}, remain in S_FETCH.
REQ-018 S_FETCH, PC_LdNew without Mem_Ack: latch target into redirect register, go S_DISCARD.
REQ-019 S_DISCARD: Mem_Req=1, Mem_Addr=old PC; further PC_LdNew SHALL overwrite the latched target; on Mem_Ack: discard data, PC<=latched target (or PC_New if PC_LdNew in that same cycle), go S_FETCH.
REQ-020 S_HOLD: Mem_Req=0, Instr_Valid=1; Instr and PC_Out SHALL hold.
REQ-021 S_HOLD, Stall=0 and no PC_LdNew: instruction consumed this cycle; go S_FETCH, Instr_Valid=0 next cycle.
REQ-022 S_HOLD, PC_LdNew (regardless of Stall): PC<={PC_New[31:2],2'b00}, Instr_Valid=0 next cycle, go S_FETCH.
REQ-023 Priority SHALL be Reset > PC_LdNew > Mem_Ack > Stall.
REQ-024 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-025 Instr_Valid SHALL be 1 only in S_HOLD; latency Mem_Ack -> Instr_Valid is exactly 1 cycle.
REQ-026 Mem_Ack outside S_FETCH/S_DISCARD SHALL be ignored.

Reset
REQ-027 On Reset: PC<=RESET_PC, state<=S_FETCH, Instr<=0, PC_Out<=0, Instr_Valid<=0, redirect register<=0.
REQ-028 Mem_Req SHALL be 0 during any cycle with Reset high; first request in the cycle after Reset falls.
REQ-029 Reset mid-fetch SHALL abandon the outstanding request; a Mem_Ack in the reset cycle is ignored.

Structure
REQ-030 Shared package SHALL hold state encodings (2-bit), RESET_PC default, and the PC increment constant 4.
REQ-031 Instr and PC_Out SHALL be built from reg32 sub-module instances (WE = capture enable, Reset shared).
REQ-032 PC, state and redirect registers SHALL live in ifetch_stage; no latches, no async logic.

Verification
REQ-033 Reset, then Mem_Ack with Mem_Rdata=32'h2000_0005 in the first fetch cycle -> next cycle Instr_Valid=1, Instr=32'h2000_0005, PC_Out=0, Mem_Req=0.
REQ-034 Stall=1 for 3 cycles in S_HOLD -> Instr/PC_Out unchanged, Instr_Valid=1 throughout; Stall=0 -> next Mem_Addr=32'h0000_0004.
REQ-035 PC_LdNew with PC_New=32'h0000_0103 during wait, Mem_Ack 2 cycles later -> data discarded, Instr_Valid stays 0, next Mem_Addr=32'h0000_0100.
REQ-036 PC_LdNew (PC_New=32'h40) coincident with Mem_Ack in S_FETCH -> no Instr_Valid, next Mem_Addr=32'h40.
REQ-037 RESET_PC=32'hFFFF_FFFC, one fetch completes -> PC_Out=32'hFFFF_FFFC, next Mem_Addr=32'h0000_0000.
REQ-038 Reset asserted while Mem_Req=1 and Mem_Ack in the same cycle -> Instr=0, Instr_Valid=0, Mem_Addr=RESET_PC after Reset falls.
